bat_charge_ctrl: RTL and testbench

// - Digital sequencer for the Li-Po charger datapath: runs trickle (TC), constant-current (CC),

---
 rtl/bat_charge_if.sv | 28 ++
 rtl/bat_charge_ctrl.sv | 162 ++++++++++++++++
 tb/tb_bat_charge_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/bat_charge_if.sv
// Charger sequencer bus: ADC sample inputs toward the controller and
// mode flags / reference codes toward the analog power stage.
interface bat_charge_if #(
    parameter int DW = 8
);
    logic          en;
    logic [3:0]    sel;
    logic          adc_valid;
    logic [DW-1:0] vbat_code;
    logic [DW-1:0] ibat_code;
    logic [DW-1:0] vtbat_code;
    logic          tc;
    logic          cc;
    logic          cv;
    logic          done;
    logic          fault;
    logic [DW-1:0] iref;
    logic [DW-1:0] vref;

    modport master (
        output en, sel, adc_valid, vbat_code, ibat_code, vtbat_code,
        input  tc, cc, cv, done, fault, iref, vref
    );
    modport slave (
        input  en, sel, adc_valid, vbat_code, ibat_code, vtbat_code,
        output tc, cc, cv, done, fault, iref, vref
    );
endinterface

// File: rtl/bat_charge_ctrl.sv
// Li-Po charge sequencer (TC -> CC -> CV -> DONE) driving the analog power stage.
// Optional thermal pause: define TEMP_PROTECT_EN.
module bat_charge_ctrl #(
    parameter int            DW        = 8,
    parameter logic [DW-1:0] VPRESET   = 8'd150,
    parameter logic [DW-1:0] VCUTOFF   = 8'd210,
    parameter logic [DW-1:0] VRECHARGE = 8'd205,
    parameter logic [DW-1:0] ICC_UNIT  = 8'd18,
    parameter logic [19:0]   TCV_MAX   = 20'd600000
`ifdef TEMP_PROTECT_EN
   ,parameter logic [DW-1:0] TEMP_LO   = 8'd60,
    parameter logic [DW-1:0] TEMP_HI   = 8'd200
`endif
) (
    input  logic         clk,
    input  logic         rst,
    bat_charge_if.slave  bus
);

`ifdef TEMP_PROTECT_EN
    typedef enum logic [2:0] {S_IDLE, S_TC, S_CC, S_CV, S_DONE, S_PAUSE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_TC, S_CC, S_CV, S_DONE} state_t;
`endif

    state_t        state_q, state_d;
    logic [3:0]    sel_q, sel_d;
    logic [19:0]   tcv_q, tcv_d, tcv_inc;
    logic          tc_q, tc_d, cc_q, cc_d, cv_q, cv_d, done_q, done_d, fault_q, fault_d;
    logic [DW-1:0] iref_q, iref_d, vref_q, vref_d;
    logic [DW-1:0] icc_now, icc_nxt, icut;

    // Saturating sel*ICC_UNIT; the product needs 4 extra bits before clamping.
    function automatic logic [DW-1:0] icc_of(input logic [3:0] s);
        logic [DW+3:0] p;
        p = {{DW{1'b0}}, s} * {4'd0, ICC_UNIT};
        return (p > {4'd0, {DW{1'b1}}}) ? {DW{1'b1}} : p[DW-1:0];
    endfunction

    assign icc_now = icc_of(sel_q);
    assign icc_nxt = icc_of(sel_d);
    assign icut    = icc_now >> 4;
    // Timeout looks at the post-increment count, so cv stays high exactly TCV_MAX cycles.
    assign tcv_inc = (tcv_q == TCV_MAX) ? tcv_q : tcv_q + 20'd1;

`ifdef TEMP_PROTECT_EN
    logic [1:0] cnt_q, cnt_d;
    logic       temp_bad;
    assign temp_bad = (bus.vtbat_code < TEMP_LO) || (bus.vtbat_code > TEMP_HI);
`else
    logic unused_vtbat;
    assign unused_vtbat = ^bus.vtbat_code;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= 4'd1;
            tcv_q   <= '0;
            tc_q    <= 1'b0;
            cc_q    <= 1'b0;
            cv_q    <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            iref_q  <= '0;
            vref_q  <= '0;
`ifdef TEMP_PROTECT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            tcv_q   <= tcv_d;
            tc_q    <= tc_d;
            cc_q    <= cc_d;
            cv_q    <= cv_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            iref_q  <= iref_d;
            vref_q  <= vref_d;
`ifdef TEMP_PROTECT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        tcv_d   = '0;
`ifdef TEMP_PROTECT_EN
        cnt_d   = cnt_q;
`endif
        if (!bus.en) begin
            state_d = S_IDLE;
        end else if (bus.adc_valid) begin
`ifdef TEMP_PROTECT_EN
            if (temp_bad && state_q != S_IDLE && state_q != S_PAUSE) begin
                state_d = S_PAUSE;
                cnt_d   = '0;
            end else
`endif
            case (state_q)
                S_IDLE: begin
                    sel_d = (bus.sel == 4'd0) ? 4'd1 : bus.sel;
                    if (bus.vbat_code < VPRESET)        state_d = S_TC;
                    else if (bus.vbat_code < VRECHARGE) state_d = S_CC;
                    else                                state_d = S_DONE;
                end
                S_TC:   if (bus.vbat_code >= VPRESET) state_d = S_CC;
                S_CC:   if (bus.vbat_code >= VCUTOFF) state_d = S_CV;
                S_CV:   if (bus.ibat_code < icut || tcv_inc == TCV_MAX) state_d = S_DONE;
                S_DONE: if (bus.vbat_code < VRECHARGE) state_d = S_CC;
`ifdef TEMP_PROTECT_EN
                S_PAUSE: begin
                    if (temp_bad) cnt_d = '0;
                    else if (cnt_q == 2'd3) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else cnt_d = cnt_q + 2'd1;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
        if (state_q == S_CV && state_d == S_CV) tcv_d = tcv_inc;
    end

    // Outputs decoded from the next state so the registered copies land with latency 1.
    always_comb begin
        tc_d    = (state_d == S_TC);
        cc_d    = (state_d == S_CC);
        cv_d    = (state_d == S_CV);
        done_d  = (state_d == S_DONE);
        fault_d = 1'b0;
        iref_d  = '0;
        vref_d  = '0;
        case (state_d)
            S_TC: begin
                iref_d = icc_nxt >> 3;
                vref_d = VCUTOFF;
            end
            S_CC, S_CV: begin
                iref_d = icc_nxt;
                vref_d = VCUTOFF;
            end
`ifdef TEMP_PROTECT_EN
            S_PAUSE: fault_d = 1'b1;
`endif
            default: ;
        endcase
    end

    assign bus.tc    = tc_q;
    assign bus.cc    = cc_q;
    assign bus.cv    = cv_q;
    assign bus.done  = done_q;
    assign bus.fault = fault_q;
    assign bus.iref  = iref_q;
    assign bus.vref  = vref_q;

endmodule

// File: tb/tb_bat_charge_ctrl.sv
// Bench for bat_charge_ctrl: constant vector table, hand sequences for timeout/reset/thermal,
// and randomized stimulus against a mode-level reference model.
module tb_bat_charge_ctrl;
    localparam int TCV = 40;

    logic clk = 1'b0;
    logic rst;
    bat_charge_if #(.DW(8)) bus ();
    bat_charge_ctrl #(.TCV_MAX(20'd40)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         en;
        logic [3:0] sel;
        bit         av;
        int         vbat;
        int         ibat;
        logic [3:0] fl;   // {tc,cc,cv,done}
        int         iref;
        int         vref;
    } vec_t;
    vec_t tbl[$];

    string m_mode;
    int    m_sel;
    int    m_cvn;

    function automatic logic [31:0] pk(logic [3:0] fl, bit f, int ir, int vr);
        return {11'd0, fl, f, 8'(ir), 8'(vr)};
    endfunction

    function automatic logic [31:0] outv();
        return {11'd0, bus.tc, bus.cc, bus.cv, bus.done, bus.fault, bus.iref, bus.vref};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (fl|fault|iref|vref)", nm, act, exp);
        end
    endtask

    task automatic drive(bit en, logic [3:0] sel, bit av, int vbat, int ibat, int vt);
        bus.en         = en;
        bus.sel        = sel;
        bus.adc_valid  = av;
        bus.vbat_code  = 8'(vbat);
        bus.ibat_code  = 8'(ibat);
        bus.vtbat_code = 8'(vt);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mdl_reset();
        m_mode = "IDLE";
        m_sel  = 1;
        m_cvn  = 0;
    endtask

    task automatic mdl_step(bit en, logic [3:0] sel, bit av, int vbat, int ibat);
        string nxt;
        int    icc;
        nxt = m_mode;
        icc = (m_sel * 18 > 255) ? 255 : m_sel * 18;
        if (m_mode == "CV" && m_cvn < TCV) m_cvn++;
        if (!en) nxt = "IDLE";
        else if (av) begin
            if (m_mode == "IDLE") begin
                m_sel = (sel == 0) ? 1 : int'(sel);
                if (vbat < 150)      nxt = "TC";
                else if (vbat < 205) nxt = "CC";
                else                 nxt = "DONE";
            end else if (m_mode == "TC" && vbat >= 150) nxt = "CC";
            else if (m_mode == "CC" && vbat >= 210) nxt = "CV";
            else if (m_mode == "CV" && (ibat < icc / 16 || m_cvn >= TCV)) nxt = "DONE";
            else if (m_mode == "DONE" && vbat < 205) nxt = "CC";
        end
        if (nxt != "CV" || m_mode != "CV") m_cvn = 0;
        m_mode = nxt;
    endtask

    function automatic logic [31:0] mdl_out();
        int icc;
        icc = (m_sel * 18 > 255) ? 255 : m_sel * 18;
        if (m_mode == "TC")   return pk(4'b1000, 1'b0, icc / 8, 210);
        if (m_mode == "CC")   return pk(4'b0100, 1'b0, icc, 210);
        if (m_mode == "CV")   return pk(4'b0010, 1'b0, icc, 210);
        if (m_mode == "DONE") return pk(4'b0001, 1'b0, 0, 0);
        return pk(4'b0000, 1'b0, 0, 0);
    endfunction

    task automatic step(string nm, bit en, logic [3:0] sel, bit av, int vbat, int ibat);
        drive(en, sel, av, vbat, ibat, 128);
        mdl_step(en, sel, av, vbat, ibat);
        tick();
        chk(nm, outv(), mdl_out());
    endtask

    task automatic do_reset();
        drive(0, 4'd0, 0, 0, 0, 128);
        rst = 1'b1;
        #1;
        chk("reset", outv(), pk(4'b0000, 1'b0, 0, 0));
        tick();
        rst = 1'b0;
        mdl_reset();
    endtask

    task automatic add(bit en, logic [3:0] sel, bit av, int vbat, int ibat,
                       logic [3:0] fl, int ir, int vr);
        vec_t v;
        v.en = en; v.sel = sel; v.av = av; v.vbat = vbat; v.ibat = ibat;
        v.fl = fl; v.iref = ir; v.vref = vr;
        tbl.push_back(v);
    endtask

    initial begin
        int n;
        bit seen_done;
        add(1, 4'd0,  1, 140, 90, 4'b1000, 2,   210);  // sel 0 -> 1, itc=2
        add(1, 4'd5,  1, 149, 90, 4'b1000, 2,   210);  // sel change ignored
        add(1, 4'd1,  0, 200, 90, 4'b1000, 2,   210);  // no strobe, no move
        add(1, 4'd1,  1, 150, 90, 4'b0100, 18,  210);  // equality crosses
        add(1, 4'd1,  1, 209, 90, 4'b0100, 18,  210);
        add(1, 4'd1,  1, 210, 90, 4'b0010, 18,  210);
        add(1, 4'd1,  1, 212, 1,  4'b0010, 18,  210);  // ibat == icut stays
        add(1, 4'd1,  1, 212, 0,  4'b0001, 0,   0);
        add(1, 4'd1,  1, 205, 90, 4'b0001, 0,   0);
        add(1, 4'd1,  1, 204, 90, 4'b0100, 18,  210);
        add(0, 4'd1,  1, 100, 90, 4'b0000, 0,   0);    // en low beats strobe
        add(1, 4'd15, 1, 180, 90, 4'b0100, 255, 210);  // saturated icc
        add(0, 4'd15, 0, 180, 90, 4'b0000, 0,   0);
        add(1, 4'd2,  1, 230, 90, 4'b0001, 0,   0);
        add(1, 4'd2,  1, 204, 90, 4'b0100, 36,  210);
        add(0, 4'd2,  1, 204, 90, 4'b0000, 0,   0);
        add(1, 4'd8,  1, 100, 90, 4'b1000, 18,  210);
        add(1, 4'd14, 1, 100, 90, 4'b1000, 18,  210);

        rst = 1'b0;
        drive(0, 4'd0, 0, 0, 0, 128);
        #2;
        do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].sel, tbl[i].av, tbl[i].vbat, tbl[i].ibat, 128);
            tick();
            chk($sformatf("vec%0d", i), outv(), pk(tbl[i].fl, 1'b0, tbl[i].iref, tbl[i].vref));
        end

        // Ramp through TC/CC/CV, then current-based end of charge and recharge.
        do_reset();
        for (int v = 140; v <= 215; v++) step("ramp", 1, 4'd1, 1, v, 90);
        chk("ramp_cv", outv(), pk(4'b0010, 1'b0, 18, 210));
        step("cv_ibat1", 1, 4'd1, 1, 215, 1);
        step("cv_ibat0", 1, 4'd1, 1, 215, 0);
        chk("eoc_done", outv(), pk(4'b0001, 1'b0, 0, 0));
        step("recharge", 1, 4'd1, 1, 204, 90);
        chk("recharge_cc", outv(), pk(4'b0100, 1'b0, 18, 210));

        // CV timeout: cv must be visible for exactly TCV cycles.
        do_reset();
        step("to_cc", 1, 4'd1, 1, 200, 90);
        step("to_cv", 1, 4'd1, 1, 210, 90);
        n = bus.cv ? 1 : 0;
        seen_done = 1'b0;
        for (int k = 0; k < 4 * TCV && !seen_done; k++) begin
            drive(1, 4'd1, 1, 212, 90, 128);
            tick();
            if (bus.cv) n++;
            if (bus.done) seen_done = 1'b1;
        end
        chk("timeout_seen", 32'(seen_done), 32'd1);
        chk("timeout_len", 32'(n), 32'(TCV));

        // Asynchronous reset mid-CV takes effect before the next edge.
        do_reset();
        step("r_cc", 1, 4'd1, 1, 200, 90);
        step("r_cv", 1, 4'd1, 1, 210, 90);
        #2 rst = 1'b1;
        #1 chk("rst_async", outv(), pk(4'b0000, 1'b0, 0, 0));
        tick();
        rst = 1'b0;
        mdl_reset();
        step("post_rst", 1, 4'd0, 1, 180, 90);

`ifdef TEMP_PROTECT_EN
        do_reset();
        drive(1, 4'd1, 1, 180, 90, 128); tick();
        chk("t_cc", outv(), pk(4'b0100, 1'b0, 18, 210));
        drive(1, 4'd1, 1, 180, 90, 250); tick();
        chk("t_pause", outv(), pk(4'b0000, 1'b1, 0, 0));
        for (int k = 0; k < 3; k++) begin
            drive(1, 4'd1, 1, 180, 90, 128); tick();
            chk("t_hold", outv(), pk(4'b0000, 1'b1, 0, 0));
        end
        drive(1, 4'd1, 1, 180, 90, 128); tick();
        chk("t_exit", outv(), pk(4'b0000, 1'b0, 0, 0));
        drive(1, 4'd1, 1, 180, 90, 128); tick();
        chk("t_resume", outv(), pk(4'b0100, 1'b0, 18, 210));
`endif

        // Randomized run against the mode-level model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            step("rand", ($urandom_range(0, 99) < 97), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), int'($urandom_range(135, 225)),
                 int'($urandom_range(0, 30)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
